tcdm_varlat_bank_arbiter: RTL

//  Per-bank arbiter for the variable-latency TCDM crossbar: shares one slave bank among NumIn

---
 rtl/tcdm_varlat_bank_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/tcdm_varlat_bank_arbiter.sv
// Per-bank round-robin arbiter for the variable-latency TCDM crossbar.
// Allows one transaction in flight per bank and steers the bank response back to the granted master.
module tcdm_varlat_bank_arbiter #(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned LogNumIn      = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [RespDataWidth-1:0]             rdata_o,
    output logic                                 req_o,
    output logic [ReqDataWidth-1:0]              data_o,
    input  logic                                 gnt_i,
    input  logic                                 vld_i,
    input  logic [RespDataWidth-1:0]             rdata_i
);

    typedef enum logic {
        IDLE,
        INFLIGHT
    } state_e;

    state_e              fsm_q, fsm_d;
    logic [LogNumIn-1:0] rr_q, rr_d;
    logic [LogNumIn-1:0] id_q, id_d;
    logic [LogNumIn-1:0] winner;
    logic                open;
    logic                handshake;

    // First requester at or after ptr, wrapping at NumIn-1 rather than at 2^LogNumIn.
    function automatic logic [LogNumIn-1:0] rr_pick(input logic [NumIn-1:0]    req,
                                                    input logic [LogNumIn-1:0] ptr);
        logic [LogNumIn-1:0] pick;
        logic [LogNumIn-1:0] cand;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NumIn); k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(NumIn)) begin
                idx = idx - int'(NumIn);
            end
            cand = LogNumIn'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [LogNumIn-1:0] rr_advance(input logic [LogNumIn-1:0] w);
        if (int'(w) >= int'(NumIn) - 1) begin
            return '0;
        end
        return LogNumIn'(int'(w) + 1);
    endfunction

    // A returning response reopens arbitration in the same cycle, giving zero-bubble back-to-back.
    always_comb begin
        open      = (fsm_q == IDLE) || vld_i;
        winner    = rr_pick(req_i, rr_q);
        req_o     = open && (|req_i);
        data_o    = data_i[winner];
        handshake = req_o && gnt_i;
        gnt_o     = '0;
        if (open) begin
            gnt_o[winner] = gnt_i;
        end
        vld_o = '0;
        if (fsm_q == INFLIGHT) begin
            vld_o[id_q] = vld_i;
        end
        rdata_o = rdata_i;
    end

    always_comb begin
        fsm_d = fsm_q;
        rr_d  = rr_q;
        id_d  = id_q;
        if (handshake) begin
            fsm_d = INFLIGHT;
            id_d  = winner;
            rr_d  = rr_advance(winner);
        end else if ((fsm_q == INFLIGHT) && vld_i) begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            rr_q  <= '0;
            id_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            rr_q  <= rr_d;
            id_q  <= id_d;
        end
    end

`ifndef SYNTHESIS
    a_num_in : assert property (@(posedge clk_i) NumIn > 0)
        else $error("NumIn must be at least 1");
    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o))
        else $error("gnt_o not one-hot");
    a_vld_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vld_o))
        else $error("vld_o not one-hot");
    a_vld_idle : assert property (@(posedge clk_i) disable iff (!rst_ni) !(vld_i && fsm_q == IDLE))
        else $error("bank response while no transaction is in flight");
`endif

endmodule
